// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: shares one physical memory port between the LC-3b
// instruction fetch side (I, read only) and the data side (D, read/write).
// One transaction is outstanding at a time. Simultaneous requests are granted
// round-robin. The downstream port is driven only from latched copies of the
// granted request. The completion is returned as a registered one-cycle pulse.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing granted; arbitrate between pending requests
// SERVE_I | downstream port carries the latched I fetch; wait for pmem_resp
// SERVE_D | downstream port carries the latched D access; wait for pmem_resp
// RESP_I  | one-cycle i_resp pulse; always returns to IDLE
// RESP_D  | one-cycle d_resp pulse; always returns to IDLE
module lc3b_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [BE_WIDTH-1:0]   d_byte_enable,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [DATA_WIDTH-1:0] pmem_wdata,
    output logic [BE_WIDTH-1:0]   pmem_byte_enable,
    input  logic [DATA_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,

    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        RESP_I  = 3'd3,
        RESP_D  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;

    // last_grant_d = 1 means D owned the previous grant, so I wins the next tie.
    logic                  last_grant_d;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [BE_WIDTH-1:0]   lat_be;

    logic                  d_req;
    logic                  grant_i;
    logic                  grant_d;
    logic                  serving;
    logic                  capture_i;
    logic                  capture_d;

    assign d_req = d_read | d_write;

    // Next-state selection and round-robin grant decision.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && i_read) begin
                    if (last_grant_d) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (d_req) begin
                    grant_d = 1'b1;
                end else if (i_read) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_next = RESP_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_next = RESP_D;
                end
            end
            RESP_I:  state_next = IDLE;
            RESP_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read data is captured only when the serving side completes a read.
    always_comb begin
        capture_i = 1'b0;
        capture_d = 1'b0;
        if (pmem_resp) begin
            capture_i = (state == SERVE_I);
            capture_d = (state == SERVE_D) && !lat_write;
        end
    end

    // State register and arbitration history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                last_grant_d <= 1'b1;
            end else if (grant_i) begin
                last_grant_d <= 1'b0;
            end
        end
    end

    // Latch the granted request; a write wins when D raises both strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (grant_d) begin
            lat_addr  <= d_address;
            lat_write <= d_write;
            lat_wdata <= d_wdata;
            lat_be    <= d_byte_enable;
        end else if (grant_i) begin
            lat_addr  <= i_address;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_be    <= '1;
        end
    end

    // Independent read-data registers, one per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (capture_i) begin
                i_rdata <= pmem_rdata;
            end
            if (capture_d) begin
                d_rdata <= pmem_rdata;
            end
        end
    end

    // Downstream port and completion pulses derive only from registered state.
    always_comb begin
        serving          = (state == SERVE_I) || (state == SERVE_D);
        pmem_read        = serving && !lat_write;
        pmem_write       = serving && lat_write;
        pmem_address     = lat_addr;
        pmem_wdata       = lat_wdata;
        pmem_byte_enable = lat_be;
        i_resp           = (state == RESP_I);
        d_resp           = (state == RESP_D);
        busy             = (state != IDLE);
    end

endmodule

// File: doc/lc3b_mem_arbiter.md
Name: lc3b_mem_arbiter

Overview:
- Shares one physical memory port between the LC-3b instruction-fetch requester (I, read-only) and the data requester (D, read/write with byte enables).
- Sits between the CPU/cache side and physical memory, and owns the sequencing of every downstream transaction.
- Latches the granted request, holds the downstream port stable until pmem_resp, then returns a one-cycle registered response to the winner.
- Round-robin arbitration on simultaneous requests, so neither side starves.

Parameters:
- ADDR_WIDTH, 16, address width on all ports.
- DATA_WIDTH, 16, data width on all ports; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- i_read  in  1  instruction read request; held high until i_resp.
- i_address  in  ADDR_WIDTH  instruction address.
- i_rdata  out  DATA_WIDTH  instruction read data; valid while i_resp=1.
- i_resp  out  1  one-cycle completion pulse to I.
- d_read  in  1  data read request; held until d_resp.
- d_write  in  1  data write request; held until d_resp.
- d_address  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_byte_enable  in  BE_WIDTH  write byte mask.
- d_rdata  out  DATA_WIDTH  data read data; valid while d_resp=1.
- d_resp  out  1  one-cycle completion pulse to D.
- pmem_read  out  1  downstream read strobe.
- pmem_write  out  1  downstream write strobe.
- pmem_address  out  ADDR_WIDTH  downstream address.
- pmem_wdata  out  DATA_WIDTH  downstream write data.
- pmem_byte_enable  out  BE_WIDTH  downstream byte mask.
- pmem_rdata  in  DATA_WIDTH  downstream read data; sampled when pmem_resp=1.
- pmem_resp  in  1  downstream completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States:
  - IDLE: nothing granted.
  - SERVE_I / SERVE_D: driving the downstream port for that requester.
  - RESP_I / RESP_D: pulsing the completion to that requester.
- Reset (sync, rst=1 at posedge):
  - state <= IDLE; last_grant <= I, so D wins the first tie.
  - All outputs 0: pmem_*, i_resp, d_resp, i_rdata, d_rdata, busy.
  - Latched request registers cleared.
  - Reset mid-transaction abandons it: no resp is issued and pmem strobes drop the next cycle.
- IDLE:
  - Only d requesting (d_read|d_write): go to SERVE_D.
  - Only i_read: go to SERVE_I.
  - Both requesting: grant the requester opposite last_grant.
  - On grant, in the same edge, latch address, op, wdata and byte_enable into internal registers and update last_grant.
  - I latches op=read and byte_enable = all ones.
  - d_read and d_write both high: treat as write.
- SERVE_x:
  - pmem_read/pmem_write and pmem_address/wdata/byte_enable are driven from the latched registers only, never combinationally from requester inputs.
  - These outputs stay stable every cycle until pmem_resp.
  - Requester input changes during SERVE are ignored.
  - On pmem_resp=1, capture pmem_rdata (reads only) into the x_rdata register and go to RESP_x.
  - Strobes deassert from RESP_x onward.
  - No timeout: SERVE waits indefinitely.
- RESP_x:
  - x_resp=1 for exactly one cycle; x_rdata holds the captured value (write: unchanged).
  - Next state is IDLE unconditionally. This absorbs the cycle in which the requester drops its strobe, so a stale request is never re-served.
- Timing and throughput:
  - Request first seen in IDLE at cycle 0; pmem strobe high from cycle 1.
  - If pmem_resp arrives in cycle k (k≥1), x_resp is high in cycle k+1 and the block is back in IDLE at cycle k+2.
  - Minimum request-to-resp: 2 cycles.
  - At most one transaction outstanding.
- Outputs:
  - i_rdata and d_rdata are independent registers, each updated only on its own read completion.
  - busy = (state != IDLE).
  - Resp signals are registered (no combinational path from pmem_resp to i_resp/d_resp).
- Simultaneous events:
  - A new request arriving during SERVE or RESP is not sampled until IDLE.
  - pmem_resp seen in a non-SERVE state is ignored.

Test Plan:
- Reset, then i_read=1, i_address=0x0040, memory returns 0x1234 with pmem_resp after 3 cycles -> pmem_read=1, pmem_address=0x0040, byte_enable=2'b11 from cycle 1; i_resp=1 for one cycle with i_rdata=0x1234 at cycle 4; d_resp stays 0.
- d_write=1, d_address=0x1001, d_wdata=0xAB00, d_byte_enable=2'b10, zero-wait memory -> pmem_write=1 with those values for exactly 1 cycle; d_resp pulse at cycle 2; pmem_read never asserts.
- i_read and d_read both held continuously from reset -> grants alternate D, I, D, I; pmem_address alternates accordingly; no two consecutive grants to the same side.
- During SERVE_D, change d_address 0x0100→0x0200 and assert i_read -> pmem_address stays 0x0100 until pmem_resp; I is granted only after RESP_D→IDLE.
- rst asserted in SERVE_I before pmem_resp -> next cycle: all outputs 0, state IDLE, no i_resp; a subsequent d_read is granted first.
- d_read=d_write=1 together -> pmem_write=1, pmem_read=0; d_rdata keeps its previous value after d_resp.
